ddr_lane_pause_sequencer: RTL
=============================

# ddr_lane_pause_sequencer

Arbitrates clock-pause requests from several lane-control requesters (DLL code update, write-leveling, read-gate training, delay-line load) and drives a single HS_IO_CLK_PAUSE for one DDR lane. It enforces a pre-pause setup window, hands the paused interval to one requester at a time, and enforces a post-pause hold and an inter-pause gap. It sits between the training/calibration engines and the lane's pause synchronizer.

## Interface
- NUM_REQ, 4: number of requesters, 1..8.
- PRE_CYCLES, 2: cycles HS_IO_CLK_PAUSE is high before grant is given, 1..15.
- POST_CYCLES, 2: cycles HS_IO_CLK_PAUSE stays high after req drops, 1..15.
- GAP_CYCLES, 4: minimum cycles HS_IO_CLK_PAUSE is low between pauses, 1..15.
- TIMEOUT_CYCLES, 255: grant watchdog limit, 16..65535. Used only with the macro below.
- CLK, input, 1: lane controller clock.
- RESET, input, 1: asynchronous, active-high.
- req, input, NUM_REQ: level request per requester. Held until the requester is finished.
- grant, output, NUM_REQ: one-hot grant, registered. Reset 0.
- HS_IO_CLK_PAUSE, output, 1: to the pause synchronizer, registered. Reset 0.
- busy, output, 1: FSM not in IDLE, registered. Reset 0.
- timeout_err, output, 1: sticky watchdog flag. Reset 0. Tied 0 when the macro is absent.

## Operation
- FSM states: IDLE, SETUP, GRANTED, HOLD, GAP. Reset state is IDLE.
- IDLE: when any req is high, the round-robin arbiter picks a winner. The search starts at the index after the last winner; after reset it starts at index 0.
  - The winner is latched into sel.
  - HS_IO_CLK_PAUSE goes to 1.
  - The FSM moves to SETUP with cnt=PRE_CYCLES-1.
- SETUP: HS_IO_CLK_PAUSE=1. cnt decrements each cycle. At cnt==0 the FSM moves to GRANTED and grant[sel] goes to 1.
- GRANTED: HS_IO_CLK_PAUSE=1 and grant[sel]=1. When req[sel]==0:
  - grant goes to 0.
  - The FSM moves to HOLD with cnt=POST_CYCLES-1.
- HOLD: HS_IO_CLK_PAUSE=1. At cnt==0:
  - HS_IO_CLK_PAUSE goes to 0.
  - The FSM moves to GAP with cnt=GAP_CYCLES-1.
- GAP: HS_IO_CLK_PAUSE=0 and new requests are ignored. At cnt==0 the FSM returns to IDLE.
- Other requests arriving during any non-IDLE state stay pending. They are arbitrated in IDLE.
- If req[sel] drops during SETUP, the pause still completes SETUP. Grant is then asserted for 1 cycle only, and the FSM goes to HOLD.
- Simultaneous requests: round-robin order only, no fixed priority. A continuously requesting index cannot starve another.
- The arbiter pointer advances to sel+1 (mod NUM_REQ) on each IDLE→SETUP transition.
- RESET mid-operation: all outputs return to 0 immediately, the FSM goes to IDLE and the pointer goes to 0. No hold or gap period is honoured.
- Counters are 4 bits wide. The watchdog counter is 16 bits wide and saturates.

## Timing
- Latency from req rising in IDLE to HS_IO_CLK_PAUSE=1: 1 cycle.
- HS_IO_CLK_PAUSE to grant: PRE_CYCLES cycles.
- req[sel] falling to grant falling: 1 cycle.
- grant falling to HS_IO_CLK_PAUSE falling: POST_CYCLES cycles.
- Minimum time HS_IO_CLK_PAUSE is low: GAP_CYCLES+1 cycles. This is from its falling edge to the earliest next rising edge.
- grant is never high while HS_IO_CLK_PAUSE is low.
- At most one grant bit is high at any time.

## Configuration
- Macro `DDR_LANE_PAUSE_TIMEOUT_EN`.
- Macro defined:
  - A watchdog counts GRANTED cycles.
  - When the count reaches TIMEOUT_CYCLES, grant is forcibly cleared and the FSM enters HOLD as if req had dropped.
  - timeout_err is set to 1 and stays set until RESET.
  - The timed-out requester must drop req before it can win arbitration again.
- Macro undefined: no watchdog logic is built, timeout_err=0, and GRANTED is held indefinitely.

## Structure
- Package ddr_lane_pause_pkg holds:
  - the state enum typedef;
  - counter widths (CNT_W=4, WDOG_W=16);
  - the maximum NUM_REQ constant.
- One sub-module, ddr_lane_pause_rr_arb: a combinational round-robin pick from req and the pointer, producing a one-hot winner and its index.
- The FSM, counters and watchdog live in the top module.

## Test plan
- Single request, defaults. req[1] rises at t0. Required response:
  - HS_IO_CLK_PAUSE=1 at t0+1.
  - grant=0010 at t0+3.
  - req drops at t5, grant=0 at t6.
  - HS_IO_CLK_PAUSE=0 at t8.
- Simultaneous req=1111 held, each dropped 3 cycles after its grant. Required response: grants in order 0,1,2,3,0, each separated by a pause low of ≥5 cycles.
- Late arrival. req[2] arrives while req[0] is GRANTED. Required response: req[2] is served only after the GAP_CYCLES gap, and HS_IO_CLK_PAUSE toggles low between the two pauses.
- Early drop. req[3] drops during SETUP. Required response: a 1-cycle grant=1000, then HOLD of 2 cycles, then GAP.
- Reset mid-operation. RESET pulse during GRANTED. Required response: grant=0, HS_IO_CLK_PAUSE=0 and busy=0 at the same time. The next req[0] is served first.
- Watchdog, with `DDR_LANE_PAUSE_TIMEOUT_EN` defined and TIMEOUT_CYCLES=16. req[0] is held high. Required response:
  - grant clears after 16 cycles.
  - timeout_err=1.
  - HS_IO_CLK_PAUSE falls POST_CYCLES cycles later.
  - There is no re-grant until req[0] drops.

Source files
------------

// File: rtl/ddr_lane_pause_pkg.sv
// Shared types and constants for the DDR lane clock-pause sequencer.
// The optional grant watchdog is enabled by defining DDR_LANE_PAUSE_TIMEOUT_EN.
package ddr_lane_pause_pkg;

  localparam int CNT_W   = 4;
  localparam int WDOG_W  = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_GRANTED = 3'd2,
    ST_HOLD    = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  // Index width for n requesters; never zero so a single requester still has a pointer bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr_lane_pause_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping to index 0.
module ddr_lane_pause_rr_arb
  import ddr_lane_pause_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               win_vld,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [SEL_W-1:0]   win_idx
);

  // Upper pass covers indices >= ptr; the lower pass only fires when nothing
  // there is requesting, so it naturally picks the wrapped-around winner.
  always_comb begin
    win_vld = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req[i] && (i >= int'(ptr))) begin
        win_vld    = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld    = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/ddr_lane_pause_sequencer.sv
// Arbitrates lane clock-pause requests and sequences HS_IO_CLK_PAUSE with setup, hold and gap.
// Define DDR_LANE_PAUSE_TIMEOUT_EN to build the grant watchdog and sticky timeout_err.
module ddr_lane_pause_sequencer
  import ddr_lane_pause_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PRE_CYCLES     = 2,
  parameter int POST_CYCLES    = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               HS_IO_CLK_PAUSE,
  output logic               busy,
  output logic               timeout_err,
  output state_e             dbg_state
);

  localparam int SEL_W = idx_w(NUM_REQ);
  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(POST_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REQ - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] sel_oh_q, sel_oh_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               pause_q, pause_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] elig;
  logic               win_vld;
  logic [NUM_REQ-1:0] win_oh;
  logic [SEL_W-1:0]   win_idx;
  logic               req_sel;
  logic               wdog_hit;

  assign req_sel = |(req & sel_oh_q);

  ddr_lane_pause_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_arb (
    .req     (elig),
    .ptr     (ptr_q),
    .win_vld (win_vld),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef DDR_LANE_PAUSE_TIMEOUT_EN
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;
  logic               terr_q, terr_d;

  // A timed-out requester stays masked from arbitration until it lowers req.
  assign wdog_hit = (state_q == ST_GRANTED) && req_sel && (wdog_q >= WDOG_LIM);
  assign elig     = req & ~blk_q;

  always_comb begin
    wdog_d = wdog_q;
    blk_d  = blk_q & req;
    terr_d = terr_q;
    if (state_q != ST_GRANTED) begin
      wdog_d = '0;
    end else if (wdog_q != {WDOG_W{1'b1}}) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    if (wdog_hit) begin
      blk_d  = blk_d | sel_oh_q;
      terr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wdog_q <= '0;
      blk_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      blk_q  <= blk_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_cfg;

  assign unused_cfg  = (TIMEOUT_CYCLES != 0);
  assign wdog_hit    = 1'b0;
  assign elig        = req;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_oh_d = sel_oh_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    pause_d  = pause_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        pause_d = 1'b0;
        if (win_vld) begin
          sel_oh_d = win_oh;
          ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + SEL_W'(1);
          pause_d  = 1'b1;
          cnt_d    = PRE_LD;
          state_d  = ST_SETUP;
        end
      end
      // Setup always runs to completion, even if the winner has already let go.
      ST_SETUP: begin
        if (cnt_q == '0) begin
          grant_d = sel_oh_q;
          state_d = ST_GRANTED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GRANTED: begin
        if (!req_sel || wdog_hit) begin
          grant_d = '0;
          cnt_d   = POST_LD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          pause_d = 1'b0;
          cnt_d   = GAP_LD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        pause_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_oh_q <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      pause_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_oh_q <= sel_oh_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      pause_q  <= pause_d;
      busy_q   <= busy_d;
    end
  end

  assign grant           = grant_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign busy            = busy_q;
  assign dbg_state       = state_q;

endmodule
